// File: rtl/pulse_compressor_if.sv
// Pulse compressor bus: the raw level input plus every measurement/strobe
// output of the compressor, grouped so one connection carries the whole link.
//   pulse_in    : asynchronous level pulse (driven by the source side)
//   pulse_out   : one-cycle strobe when a pulse qualifies
//   width_out   : last measured high width, held until the next update
//   width_valid : one-cycle strobe, width_out updated this cycle
//   glitch      : one-cycle strobe, pulse rejected as too short
//   overflow    : sticky, last measured pulse saturated the counter
//   busy        : compressor is tracking a pulse
interface pulse_compressor_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 pulse_in;
    logic                 pulse_out;
    logic [CNT_WIDTH-1:0] width_out;
    logic                 width_valid;
    logic                 glitch;
    logic                 overflow;
    logic                 busy;

    // Source/consumer side: drives the level, observes the results.
    modport master (
        output pulse_in,
        input  pulse_out,
        input  width_out,
        input  width_valid,
        input  glitch,
        input  overflow,
        input  busy
    );

    // Compressor side.
    modport slave (
        input  pulse_in,
        output pulse_out,
        output width_out,
        output width_valid,
        output glitch,
        output overflow,
        output busy
    );
endinterface

// File: rtl/pulse_compressor.sv
// Pulse compressor: synchronises a long level pulse to clk_in, rejects pulses
// shorter than MIN_WIDTH synchronised-high cycles, emits a one-cycle strobe on
// qualification and reports the measured high width when the pulse ends.
// Ports:
//   clk_in : system clock, all logic on the rising edge
//   rst    : synchronous active-low reset
//   bus    : pulse_compressor_if slave (pulse_in in; pulse_out, width_out,
//            width_valid, glitch, overflow, busy out)
module pulse_compressor #(
    parameter int unsigned MIN_WIDTH = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    pulse_compressor_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] MIN_CNT  = CNT_WIDTH'(MIN_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        QUAL   = 2'b01,
        ACTIVE = 2'b10
    } state_t;

    state_t               state;
    state_t               state_d;
    logic                 s1;
    logic                 s2;
    logic                 in_s;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 pulse_q;
    logic                 pulse_d;
    logic [CNT_WIDTH-1:0] width_q;
    logic [CNT_WIDTH-1:0] width_d;
    logic                 width_valid_q;
    logic                 width_valid_d;
    logic                 glitch_q;
    logic                 glitch_d;
    logic                 overflow_q;
    logic                 overflow_d;

    // Two-flop synchroniser; nothing else looks at the raw input.
    assign in_s = s2;

    // State and output registers; reset aborts any pulse in flight.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            state         <= IDLE;
            cnt           <= CNT_ZERO;
            pulse_q       <= 1'b0;
            width_q       <= CNT_ZERO;
            width_valid_q <= 1'b0;
            glitch_q      <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            s1            <= bus.pulse_in;
            s2            <= s1;
            state         <= state_d;
            cnt           <= cnt_d;
            pulse_q       <= pulse_d;
            width_q       <= width_d;
            width_valid_q <= width_valid_d;
            glitch_q      <= glitch_d;
            overflow_q    <= overflow_d;
        end
    end

    assign cnt_inc = cnt + CNT_ONE;

    // Next-state and next-output logic; strobes default low every cycle.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        pulse_d       = 1'b0;
        width_d       = width_q;
        width_valid_d = 1'b0;
        glitch_d      = 1'b0;
        overflow_d    = overflow_q;

        case (state)
            IDLE: begin
                if (in_s) begin
                    cnt_d = CNT_ONE;
                    if (MIN_WIDTH == 1) begin
                        // First high sample already qualifies.
                        state_d    = ACTIVE;
                        pulse_d    = 1'b1;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = QUAL;
                    end
                end
            end

            QUAL: begin
                if (in_s) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MIN_CNT) begin
                        state_d    = ACTIVE;
                        pulse_d    = 1'b1;
                        overflow_d = 1'b0;
                    end
                end else begin
                    // Too short: reject, keep the previous width report.
                    state_d  = IDLE;
                    glitch_d = 1'b1;
                    cnt_d    = CNT_ZERO;
                end
            end

            ACTIVE: begin
                if (in_s) begin
                    // Saturate rather than wrap so a huge pulse reads as max.
                    if (cnt == CNT_MAX) begin
                        overflow_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d       = IDLE;
                    width_d       = cnt;
                    width_valid_d = 1'b1;
                    cnt_d         = CNT_ZERO;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    assign bus.pulse_out   = pulse_q;
    assign bus.width_out   = width_q;
    assign bus.width_valid = width_valid_q;
    assign bus.glitch      = glitch_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_pulse_compressor.sv
// Bench for pulse_compressor: three instances (MIN_WIDTH/CNT_WIDTH = 4/32,
// 4/8, 1/32). Each test pushes the expected strobe sequence into a per-DUT
// queue; a negedge monitor pops and compares every strobe the DUT emits.
module tb_pulse_compressor;

    localparam logic [1:0] K_PO = 2'd0;
    localparam logic [1:0] K_GL = 2'd1;
    localparam logic [1:0] K_WV = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] width;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    exp_t q4[$];
    exp_t q8[$];
    exp_t q1[$];

    pulse_compressor_if #(.CNT_WIDTH(32)) if4 ();
    pulse_compressor_if #(.CNT_WIDTH(8))  if8 ();
    pulse_compressor_if #(.CNT_WIDTH(32)) if1 ();

    pulse_compressor #(.MIN_WIDTH(4), .CNT_WIDTH(32)) u4 (
        .clk_in(clk), .rst(rst), .bus(if4.slave)
    );
    pulse_compressor #(.MIN_WIDTH(4), .CNT_WIDTH(8)) u8 (
        .clk_in(clk), .rst(rst), .bus(if8.slave)
    );
    pulse_compressor #(.MIN_WIDTH(1), .CNT_WIDTH(32)) u1 (
        .clk_in(clk), .rst(rst), .bus(if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] kind, input int unsigned width, input logic ovf);
        exp_t e;
        e.kind  = kind;
        e.width = 32'(width);
        e.ovf   = ovf;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    // Scoreboard monitors: each strobe pops one expectation.
    always @(negedge clk) begin : mon4
        logic [2:0] st;
        exp_t e;
        st = {if4.width_valid, if4.glitch, if4.pulse_out};
        for (int k = 0; k < 3; k++) begin
            if (st[k] === 1'b1) begin
                compared++;
                if (q4.size() == 0) begin
                    mismatched++;
                    $display("FAIL u4_event: unexpected strobe kind=%0d at %0t", k, $time);
                end else begin
                    e = q4.pop_front();
                    if (e.kind !== 2'(k) || 32'(if4.width_out) !== e.width || if4.overflow !== e.ovf) begin
                        mismatched++;
                        $display("FAIL u4_event: got kind=%0d width=%0d ovf=%0b, want kind=%0d width=%0d ovf=%0b",
                                 k, if4.width_out, if4.overflow, e.kind, e.width, e.ovf);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : mon8
        logic [2:0] st;
        exp_t e;
        st = {if8.width_valid, if8.glitch, if8.pulse_out};
        for (int k = 0; k < 3; k++) begin
            if (st[k] === 1'b1) begin
                compared++;
                if (q8.size() == 0) begin
                    mismatched++;
                    $display("FAIL u8_event: unexpected strobe kind=%0d at %0t", k, $time);
                end else begin
                    e = q8.pop_front();
                    if (e.kind !== 2'(k) || 32'(if8.width_out) !== e.width || if8.overflow !== e.ovf) begin
                        mismatched++;
                        $display("FAIL u8_event: got kind=%0d width=%0d ovf=%0b, want kind=%0d width=%0d ovf=%0b",
                                 k, if8.width_out, if8.overflow, e.kind, e.width, e.ovf);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [2:0] st;
        exp_t e;
        st = {if1.width_valid, if1.glitch, if1.pulse_out};
        for (int k = 0; k < 3; k++) begin
            if (st[k] === 1'b1) begin
                compared++;
                if (q1.size() == 0) begin
                    mismatched++;
                    $display("FAIL u1_event: unexpected strobe kind=%0d at %0t", k, $time);
                end else begin
                    e = q1.pop_front();
                    if (e.kind !== 2'(k) || 32'(if1.width_out) !== e.width || if1.overflow !== e.ovf) begin
                        mismatched++;
                        $display("FAIL u1_event: got kind=%0d width=%0d ovf=%0b, want kind=%0d width=%0d ovf=%0b",
                                 k, if1.width_out, if1.overflow, e.kind, e.width, e.ovf);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        settle(3);
        compared++;
        if ({if4.pulse_out, if4.width_valid, if4.glitch, if4.overflow, if4.busy} !== 5'b0 || if4.width_out !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_u4: flags=%b width=%0d, want 0/0",
                     {if4.pulse_out, if4.width_valid, if4.glitch, if4.overflow, if4.busy}, if4.width_out);
        end
        compared++;
        if ({if8.pulse_out, if8.width_valid, if8.glitch, if8.overflow, if8.busy} !== 5'b0 || if8.width_out !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_u8: flags=%b width=%0d, want 0/0",
                     {if8.pulse_out, if8.width_valid, if8.glitch, if8.overflow, if8.busy}, if8.width_out);
        end
        compared++;
        if ({if1.pulse_out, if1.width_valid, if1.glitch, if1.overflow, if1.busy} !== 5'b0 || if1.width_out !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_u1: flags=%b width=%0d, want 0/0",
                     {if1.pulse_out, if1.width_valid, if1.glitch, if1.overflow, if1.busy}, if1.width_out);
        end
        rst = 1'b1;
        settle(2);
    endtask

    // 300-cycle pulse: exact strobe timing and busy window, edge by edge.
    task automatic test_long_pulse();
        q4.push_back(mk(K_PO, 0, 1'b0));
        q4.push_back(mk(K_WV, 300, 1'b0));
        if4.pulse_in = 1'b1;
        for (int e = 1; e <= 315; e++) begin
            tick();
            if (e == 300) if4.pulse_in = 1'b0;
            compared++;
            if (if4.pulse_out !== (e == 6)) begin
                mismatched++;
                $display("FAIL long_pulse_out: edge %0d got %b want %b", e, if4.pulse_out, (e == 6));
            end
            compared++;
            if (if4.busy !== (e >= 3 && e <= 302)) begin
                mismatched++;
                $display("FAIL long_busy: edge %0d got %b want %b", e, if4.busy, (e >= 3 && e <= 302));
            end
            compared++;
            if (if4.width_valid !== (e == 303)) begin
                mismatched++;
                $display("FAIL long_width_valid: edge %0d got %b want %b", e, if4.width_valid, (e == 303));
            end
        end
        compared++;
        if (q4.size() != 0) begin
            mismatched++;
            $display("FAIL long_drain: %0d events outstanding, want 0", q4.size());
        end
    endtask

    task automatic test_glitch();
        q4.push_back(mk(K_GL, 300, 1'b0));
        if4.pulse_in = 1'b1;
        settle(3);
        if4.pulse_in = 1'b0;
        settle(10);
        compared++;
        if (q4.size() != 0 || if4.width_out !== 32'd300) begin
            mismatched++;
            $display("FAIL glitch_drain: outstanding=%0d width=%0d, want 0/300", q4.size(), if4.width_out);
        end
    endtask

    task automatic test_exact_min();
        q4.push_back(mk(K_PO, 300, 1'b0));
        q4.push_back(mk(K_WV, 4, 1'b0));
        if4.pulse_in = 1'b1;
        settle(4);
        if4.pulse_in = 1'b0;
        settle(10);
        compared++;
        if (q4.size() != 0) begin
            mismatched++;
            $display("FAIL exact_min_drain: %0d events outstanding, want 0", q4.size());
        end
    endtask

    task automatic test_saturation();
        q8.push_back(mk(K_PO, 0, 1'b0));
        q8.push_back(mk(K_WV, 255, 1'b1));
        if8.pulse_in = 1'b1;
        settle(300);
        if8.pulse_in = 1'b0;
        settle(10);
        compared++;
        if (if8.overflow !== 1'b1 || q8.size() != 0) begin
            mismatched++;
            $display("FAIL sat_sticky: overflow=%b outstanding=%0d, want 1/0", if8.overflow, q8.size());
        end
        q8.push_back(mk(K_PO, 255, 1'b0));
        q8.push_back(mk(K_WV, 10, 1'b0));
        if8.pulse_in = 1'b1;
        settle(10);
        if8.pulse_in = 1'b0;
        settle(10);
        compared++;
        if (if8.overflow !== 1'b0 || q8.size() != 0) begin
            mismatched++;
            $display("FAIL sat_clear: overflow=%b outstanding=%0d, want 0/0", if8.overflow, q8.size());
        end
    endtask

    task automatic test_back_to_back();
        q1.push_back(mk(K_PO, 0, 1'b0));
        q1.push_back(mk(K_WV, 5, 1'b0));
        q1.push_back(mk(K_PO, 5, 1'b0));
        q1.push_back(mk(K_WV, 7, 1'b0));
        if1.pulse_in = 1'b1;
        settle(5);
        if1.pulse_in = 1'b0;
        tick();
        if1.pulse_in = 1'b1;
        settle(7);
        if1.pulse_in = 1'b0;
        settle(10);
        compared++;
        if (q1.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_drain: %0d events outstanding, want 0", q1.size());
        end
    endtask

    // Reset mid-pulse: the aborted pulse reports nothing; the remainder
    // re-qualifies and measures only the samples taken after reset.
    task automatic test_reset_mid_pulse();
        int unsigned len;
        int unsigned rst_edge;
        len      = 300;
        rst_edge = 101;
        q4.push_back(mk(K_PO, 4, 1'b0));
        q4.push_back(mk(K_PO, 0, 1'b0));
        q4.push_back(mk(K_WV, len - rst_edge, 1'b0));
        if4.pulse_in = 1'b1;
        for (int e = 1; e <= int'(len); e++) begin
            tick();
            if (e == int'(rst_edge) - 1) rst = 1'b0;
            if (e == int'(rst_edge)) begin
                compared++;
                if ({if4.pulse_out, if4.width_valid, if4.glitch, if4.overflow, if4.busy} !== 5'b0 || if4.width_out !== 32'd0) begin
                    mismatched++;
                    $display("FAIL mid_reset_state: flags=%b width=%0d, want 0/0",
                             {if4.pulse_out, if4.width_valid, if4.glitch, if4.overflow, if4.busy}, if4.width_out);
                end
                rst = 1'b1;
            end
        end
        if4.pulse_in = 1'b0;
        settle(10);
        compared++;
        if (q4.size() != 0) begin
            mismatched++;
            $display("FAIL mid_reset_drain: %0d events outstanding, want 0", q4.size());
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        compared     = 0;
        mismatched   = 0;
        rst          = 1'b0;
        if4.pulse_in = 1'b0;
        if8.pulse_in = 1'b0;
        if1.pulse_in = 1'b0;
        tick();
        test_reset();
        test_long_pulse();
        test_glitch();
        test_exact_min();
        test_saturation();
        test_back_to_back();
        test_reset_mid_pulse();
        compared++;
        if (q4.size() + q8.size() + q1.size() != 0) begin
            mismatched++;
            $display("FAIL final_drain: %0d events outstanding, want 0", q4.size() + q8.size() + q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
